// File: rtl/gpu_line_pkg.sv
// Shared types for the 2D raster line path: FSM state, coordinate struct, arithmetic width helper.
// Coordinate widths up to COORD_W_MAX bits are supported by the line generator.
package gpu_line_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        STEP  = 2'd2
    } line_state_t;

    localparam int COORD_W_MAX = 16;

    // Carries both axes at the widest supported width; narrower coordinates are zero-extended.
    typedef struct packed {
        logic [COORD_W_MAX-1:0] x;
        logic [COORD_W_MAX-1:0] y;
    } coord_t;

    // Signed width that holds dx+dy and every error-term update without wrapping.
    function automatic int arith_w(input int x_w, input int y_w);
        return ((x_w > y_w) ? x_w : y_w) + 2;
    endfunction

endpackage

// File: rtl/bresen_step.sv
// Combinational Bresenham step: next error term and position from the current ones.
// Both axis decisions use the error term before either update is applied.
module bresen_step
    import gpu_line_pkg::*;
#(
    parameter int W = 12
) (
    input  logic signed [W-1:0] err,
    input  logic signed [W-1:0] dx,
    input  logic signed [W-1:0] dy,
    input  coord_t              cur,
    input  coord_t              end_pt,
    input  logic                right,
    input  logic                down,
    output logic signed [W-1:0] err_nxt,
    output coord_t              nxt,
    output logic                at_end,
    output logic                next_at_end
);

    logic signed [W:0] e2;
    logic signed [W:0] dx_ext;
    logic signed [W:0] dy_ext;
    logic              step_x;
    logic              step_y;

    always_comb begin
        e2      = {err, 1'b0};
        dx_ext  = {dx[W-1], dx};
        dy_ext  = {dy[W-1], dy};
        step_x  = e2 > dy_ext;
        step_y  = e2 < dx_ext;

        err_nxt = err;
        if (step_x) begin
            err_nxt = err_nxt + dy;
        end
        if (step_y) begin
            err_nxt = err_nxt + dx;
        end

        nxt = cur;
        if (step_x) begin
            nxt.x = right ? cur.x + COORD_W_MAX'(1) : cur.x - COORD_W_MAX'(1);
        end
        if (step_y) begin
            nxt.y = down ? cur.y + COORD_W_MAX'(1) : cur.y - COORD_W_MAX'(1);
        end

        at_end      = (cur == end_pt);
        next_at_end = (nxt == end_pt);
    end

endmodule

// File: rtl/bresen_line_gen.sv
// Bresenham line generator: one command in, one pixel per cycle out, both valid/ready.
// Define LINE_CLIP_EN to drop pixels beyond X_MAX/Y_MAX without stalling the stepper.
module bresen_line_gen
    import gpu_line_pkg::*;
#(
    parameter int X_W   = 10,
    parameter int Y_W   = 9,
    parameter int X_MAX = 639,
    parameter int Y_MAX = 479
) (
    input  logic           clk,
    input  logic           n_rst,
    input  logic           cmd_valid,
    output logic           cmd_ready,
    input  logic [X_W-1:0] cmd_x0,
    input  logic [X_W-1:0] cmd_x1,
    input  logic [Y_W-1:0] cmd_y0,
    input  logic [Y_W-1:0] cmd_y1,
    input  logic           cmd_skip_last,
    input  logic           abort,
    output logic           pix_valid,
    input  logic           pix_ready,
    output logic [X_W-1:0] pix_x,
    output logic [Y_W-1:0] pix_y,
    output logic           pix_last,
    output logic           busy,
    output logic           line_done
);

    localparam int W = arith_w(X_W, Y_W);

    // Handshakes: a transfer happens in a cycle where valid and ready are both high;
    // once raised, pix_valid and its payload hold until that transfer, abort or reset.
    line_state_t         state_q;
    line_state_t         state_nxt;
    coord_t              cur_q;
    coord_t              end_q;
    coord_t              cur_nxt;
    logic signed [W-1:0] err_q;
    logic signed [W-1:0] dx_q;
    logic signed [W-1:0] dy_q;
    logic signed [W-1:0] err_nxt;
    logic signed [W-1:0] setup_dx;
    logic signed [W-1:0] setup_dy;
    logic                right_q;
    logic                down_q;
    logic                skip_q;
    logic                done_q;
    logic                setup_right;
    logic                setup_down;
    logic                at_end;
    logic                next_at_end;
    logic                vis;
    logic                vis_nxt;
    logic                final_pix;
    logic                fire;
    logic                finish;
    logic                load;
    logic                setup;
    logic                advance;
    logic                done_nxt;

    bresen_step #(.W(W)) u_step (
        .err         (err_q),
        .dx          (dx_q),
        .dy          (dy_q),
        .cur         (cur_q),
        .end_pt      (end_q),
        .right       (right_q),
        .down        (down_q),
        .err_nxt     (err_nxt),
        .nxt         (cur_nxt),
        .at_end      (at_end),
        .next_at_end (next_at_end)
    );

`ifdef LINE_CLIP_EN
    assign vis     = (cur_q.x <= COORD_W_MAX'(X_MAX)) && (cur_q.y <= COORD_W_MAX'(Y_MAX));
    assign vis_nxt = (cur_nxt.x <= COORD_W_MAX'(X_MAX)) && (cur_nxt.y <= COORD_W_MAX'(Y_MAX));
`else
    assign vis     = 1'b1;
    assign vis_nxt = 1'b1;
`endif

    // Each axis moves monotonically, so the visible pixels form one contiguous run;
    // an invisible successor therefore means the current pixel is the last one shown.
    assign final_pix = skip_q ? next_at_end : at_end;
    assign pix_valid = (state_q == STEP) && vis && !(skip_q && at_end);
    assign pix_last  = pix_valid && (final_pix || !vis_nxt);
    assign fire      = pix_valid && pix_ready;
    assign finish    = (skip_q && at_end) || (final_pix && (fire || !vis));

    assign cmd_ready = (state_q == IDLE) && !abort;
    assign busy      = (state_q != IDLE);
    assign line_done = done_q;
    assign pix_x     = cur_q.x[X_W-1:0];
    assign pix_y     = cur_q.y[Y_W-1:0];

    assign setup_right = (end_q.x >= cur_q.x);
    assign setup_down  = (end_q.y >= cur_q.y);
    assign setup_dx    = setup_right ? W'(end_q.x) - W'(cur_q.x) : W'(cur_q.x) - W'(end_q.x);
    assign setup_dy    = setup_down  ? W'(cur_q.y) - W'(end_q.y) : W'(end_q.y) - W'(cur_q.y);

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        load      = 1'b0;
        setup     = 1'b0;
        advance   = 1'b0;
        done_nxt  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (cmd_valid && !abort) begin
                    load      = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                setup     = 1'b1;
                state_nxt = STEP;
            end
            STEP: begin
                if (finish) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (fire || !vis) begin
                    advance = 1'b1;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (abort) begin
            state_nxt = IDLE;
            done_nxt  = 1'b0;
            advance   = 1'b0;
            setup     = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            cur_q   <= '0;
            end_q   <= '0;
            err_q   <= '0;
            dx_q    <= '0;
            dy_q    <= '0;
            right_q <= 1'b0;
            down_q  <= 1'b0;
            skip_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= done_nxt;
            if (load) begin
                cur_q  <= '{x: COORD_W_MAX'(cmd_x0), y: COORD_W_MAX'(cmd_y0)};
                end_q  <= '{x: COORD_W_MAX'(cmd_x1), y: COORD_W_MAX'(cmd_y1)};
                skip_q <= cmd_skip_last;
            end
            if (setup) begin
                right_q <= setup_right;
                down_q  <= setup_down;
                dx_q    <= setup_dx;
                dy_q    <= setup_dy;
                err_q   <= setup_dx + setup_dy;
            end
            if (advance) begin
                cur_q <= cur_nxt;
                err_q <= err_nxt;
            end
        end
    end

endmodule

// File: tb/tb_bresen_line_gen.sv
// Directed bench for bresen_line_gen with hand-computed pixel sequences and cycle timing.
// With LINE_CLIP_EN defined a second instance (X_MAX=3) covers screen clipping.
module tb_bresen_line_gen;

    localparam int X_W = 10;
    localparam int Y_W = 9;
    localparam int PW  = 1 + X_W + Y_W;

    logic           clk = 1'b0;
    logic           n_rst = 1'b0;
    logic           cmd_valid = 1'b0;
    logic           cmd_ready;
    logic [X_W-1:0] cmd_x0 = '0;
    logic [X_W-1:0] cmd_x1 = '0;
    logic [Y_W-1:0] cmd_y0 = '0;
    logic [Y_W-1:0] cmd_y1 = '0;
    logic           cmd_skip_last = 1'b0;
    logic           abort = 1'b0;
    logic           pix_valid;
    logic           pix_ready = 1'b1;
    logic [X_W-1:0] pix_x;
    logic [Y_W-1:0] pix_y;
    logic           pix_last;
    logic           busy;
    logic           line_done;

    always #5 clk = ~clk;

    bresen_line_gen #(.X_W(X_W), .Y_W(Y_W), .X_MAX(639), .Y_MAX(479)) u_dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .cmd_valid     (cmd_valid),
        .cmd_ready     (cmd_ready),
        .cmd_x0        (cmd_x0),
        .cmd_x1        (cmd_x1),
        .cmd_y0        (cmd_y0),
        .cmd_y1        (cmd_y1),
        .cmd_skip_last (cmd_skip_last),
        .abort         (abort),
        .pix_valid     (pix_valid),
        .pix_ready     (pix_ready),
        .pix_x         (pix_x),
        .pix_y         (pix_y),
        .pix_last      (pix_last),
        .busy          (busy),
        .line_done     (line_done)
    );

`ifdef LINE_CLIP_EN
    logic           c_cmd_valid = 1'b0;
    logic           c_cmd_ready;
    logic           c_abort = 1'b0;
    logic           c_pix_valid;
    logic           c_pix_ready = 1'b1;
    logic [X_W-1:0] c_pix_x;
    logic [Y_W-1:0] c_pix_y;
    logic           c_pix_last;
    logic           c_busy;
    logic           c_line_done;

    bresen_line_gen #(.X_W(X_W), .Y_W(Y_W), .X_MAX(3), .Y_MAX(479)) u_clip (
        .clk           (clk),
        .n_rst         (n_rst),
        .cmd_valid     (c_cmd_valid),
        .cmd_ready     (c_cmd_ready),
        .cmd_x0        (cmd_x0),
        .cmd_x1        (cmd_x1),
        .cmd_y0        (cmd_y0),
        .cmd_y1        (cmd_y1),
        .cmd_skip_last (cmd_skip_last),
        .abort         (c_abort),
        .pix_valid     (c_pix_valid),
        .pix_ready     (c_pix_ready),
        .pix_x         (c_pix_x),
        .pix_y         (c_pix_y),
        .pix_last      (c_pix_last),
        .busy          (c_busy),
        .line_done     (c_line_done)
    );
`endif

    // ---------------- scoreboard state ----------------
    int              n_checks = 0;
    int              n_errors = 0;
    logic [PW-1:0]   exp_q[$];
    int              cyc = 0;
    int              t_cmd = -1;
    int              t_first = -1;
    int              t_last_fire = -1;
    int              t_done = -1;
    int              n_fire = 0;
    int              n_done = 0;
    int              n_valid = 0;
    int              n_busy = 0;
    logic            hold_pend = 1'b0;
    logic [PW-1:0]   hold_val = '0;
    int              rmode = 0;
    int              rcnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: samples on the falling edge, scores every pixel transfer.
    always @(negedge clk) begin
        if (n_rst) begin
            if (cmd_valid && cmd_ready) t_cmd = cyc;
            if (busy) n_busy++;
            if (pix_valid) n_valid++;
            if (line_done) begin
                n_done++;
                t_done = cyc;
            end
            if (hold_pend) check("stall_hold", {pix_valid, pix_last, pix_x, pix_y}, {1'b1, hold_val});
            hold_pend = pix_valid && !pix_ready && !abort;
            hold_val  = {pix_last, pix_x, pix_y};
            if (pix_valid && pix_ready) begin
                if (n_fire == 0) t_first = cyc;
                t_last_fire = cyc;
                n_fire++;
                if (exp_q.size() == 0) begin
                    check("pix_extra", 32'(exp_q.size()), 32'd1);
                end else begin
                    check("pix", {pix_last, pix_x, pix_y}, exp_q.pop_front());
                end
            end
        end
    end

    // Consumer ready: 0 = always ready, 1 = pattern 1,0,0,..., otherwise held low.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0: pix_ready = 1'b1;
                1: begin
                    pix_ready = (rcnt % 3 == 0);
                    rcnt++;
                end
                default: pix_ready = 1'b0;
            endcase
        end
    end

    // ---------------- driver tasks ----------------
    task automatic clear_stats();
        t_first = -1;
        t_last_fire = -1;
        t_done = -1;
        n_fire = 0;
        n_done = 0;
        n_valid = 0;
        n_busy = 0;
    endtask

    task automatic push(input int x, input int y, input bit last);
        exp_q.push_back({last, X_W'(x), Y_W'(y)});
    endtask

    task automatic send_cmd(input int x0, input int y0, input int x1, input int y1, input bit skip);
        bit ok;
        ok = 1'b0;
        @(posedge clk);
        #1;
        cmd_x0 = X_W'(x0);
        cmd_y0 = Y_W'(y0);
        cmd_x1 = X_W'(x1);
        cmd_y1 = Y_W'(y1);
        cmd_skip_last = skip;
        cmd_valid = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (cmd_ready) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("cmd_accept_timeout", 32'd0, 32'd1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input int budget);
        bit ok;
        ok = 1'b0;
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (!busy) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("idle_timeout", 32'd0, 32'd1);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        int a_cyc;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_pix_valid", pix_valid, 0);
        check("rst_pix_x", pix_x, 0);
        check("rst_pix_y", pix_y, 0);
        check("rst_pix_last", pix_last, 0);
        check("rst_busy", busy, 0);
        check("rst_line_done", line_done, 0);
        @(posedge clk);
        #1;
        n_rst = 1'b1;

        // Horizontal line, continuous ready.
        clear_stats();
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 0); push(3, 0, 1);
        send_cmd(0, 0, 3, 0, 0);
        wait_idle(30);
        check("h_first_cycle", t_first, t_cmd + 2);
        check("h_last_cycle", t_last_fire, t_cmd + 5);
        check("h_done_cycle", t_done, t_cmd + 6);
        check("h_busy_cycles", n_busy, 5);
        check("h_done_count", n_done, 1);
        check("h_fire_count", n_fire, 4);
        check("h_queue_empty", exp_q.size(), 0);

        // Steep line, negative x direction.
        clear_stats();
        push(5, 1, 0); push(5, 2, 0); push(4, 3, 0); push(4, 4, 0);
        push(3, 5, 0); push(3, 6, 0); push(2, 7, 1);
        send_cmd(5, 1, 2, 7, 0);
        wait_idle(30);
        check("steep_fire_count", n_fire, 7);
        check("steep_done_count", n_done, 1);
        check("steep_queue_empty", exp_q.size(), 0);

        // Shallow line under backpressure.
        clear_stats();
        rcnt = 0;
        rmode = 1;
        push(0, 0, 0); push(1, 0, 0); push(2, 1, 0); push(3, 1, 0); push(4, 2, 1);
        send_cmd(0, 0, 4, 2, 0);
        wait_idle(60);
        rmode = 0;
        check("stall_fire_count", n_fire, 5);
        check("stall_done_count", n_done, 1);
        check("stall_queue_empty", exp_q.size(), 0);

        // Degenerate line with end-point omission: nothing emitted.
        clear_stats();
        send_cmd(9, 9, 9, 9, 1);
        wait_idle(20);
        check("degen_skip_valid", n_valid, 0);
        check("degen_skip_done_cycle", t_done, t_cmd + 3);
        check("degen_skip_done_count", n_done, 1);
        check("degen_skip_busy", n_busy, 2);

        // Degenerate line without omission: single last pixel.
        clear_stats();
        push(9, 9, 1);
        send_cmd(9, 9, 9, 9, 0);
        wait_idle(20);
        check("degen_fire_count", n_fire, 1);
        check("degen_done_count", n_done, 1);
        check("degen_queue_empty", exp_q.size(), 0);

        // End-point omission on a real line.
        clear_stats();
        push(0, 0, 0); push(1, 0, 0); push(2, 0, 1);
        send_cmd(0, 0, 3, 0, 1);
        wait_idle(20);
        check("skip_fire_count", n_fire, 3);
        check("skip_done_cycle", t_done, t_cmd + 5);
        check("skip_queue_empty", exp_q.size(), 0);

        // Abort after the third transfer, then an immediate new command.
        clear_stats();
        push(0, 0, 0); push(1, 1, 0); push(2, 2, 0);
        send_cmd(0, 0, 10, 10, 0);
        begin
            bit ok;
            ok = 1'b0;
            for (int k = 0; k < 40; k++) begin
                @(negedge clk);
                #1;
                if (n_fire >= 3) begin
                    ok = 1'b1;
                    break;
                end
            end
            if (!ok) check("abort_wait_timeout", 32'd0, 32'd1);
        end
        rmode = 2;
        @(posedge clk);
        #1;
        abort = 1'b1;
        @(negedge clk);
        #1;
        a_cyc = cyc;
        rmode = 0;
        @(posedge clk);
        #1;
        abort = 1'b0;
        push(0, 0, 0); push(1, 0, 1);
        cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = X_W'(1); cmd_y1 = '0;
        cmd_skip_last = 1'b0;
        cmd_valid = 1'b1;
        @(negedge clk);
        #1;
        check("abort_busy", busy, 0);
        check("abort_pix_valid", pix_valid, 0);
        check("abort_cmd_ready", cmd_ready, 1);
        check("abort_no_done", n_done, 0);
        check("abort_fire_count", n_fire, 3);
        check("abort_accept_cycle", t_cmd, a_cyc + 1);
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        wait_idle(20);
        check("post_abort_fire_count", n_fire, 5);
        check("post_abort_done_count", n_done, 1);
        check("post_abort_queue_empty", exp_q.size(), 0);

`ifdef LINE_CLIP_EN
        begin
            int ct;
            int cn;
            int cdone;
            cn = 0;
            cdone = -1;
            @(posedge clk);
            #1;
            cmd_x0 = '0; cmd_y0 = '0; cmd_x1 = X_W'(6); cmd_y1 = '0;
            cmd_skip_last = 1'b0;
            c_cmd_valid = 1'b1;
            @(negedge clk);
            #1;
            ct = cyc;
            check("clip_accept", c_cmd_ready, 1);
            @(posedge clk);
            #1;
            c_cmd_valid = 1'b0;
            for (int k = 0; k < 30; k++) begin
                @(negedge clk);
                #1;
                if (c_pix_valid) begin
                    check("clip_pix", {c_pix_last, c_pix_x, c_pix_y}, {(cn == 3), X_W'(cn), Y_W'(0)});
                    cn++;
                end
                if (c_line_done) begin
                    cdone = cyc;
                    check("clip_idle", c_busy, 0);
                    break;
                end
            end
            check("clip_pix_count", cn, 4);
            check("clip_done_cycle", cdone, ct + 9);
        end
`endif

        repeat (2) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bresen_line_gen.md
# bresen_line_gen

Parametrised successor to the single-line Bresenham rasteriser in the 2D GPU raster path. Accepts one line command at a time over a valid/ready handshake and emits one pixel coordinate per cycle over a second valid/ready stream to the framebuffer address stage. Compared with the earlier generator it adds:
- configurable coordinate widths
- true backpressure in place of a stop level
- optional end-point omission for polyline joints
- abort
- optional screen-bounds clipping

## Interface
Parameters:
- X_W, 10, x coordinate width in bits
- Y_W, 9, y coordinate width in bits
- X_MAX, 639, largest visible x (used only with clipping)
- Y_MAX, 479, largest visible y (used only with clipping)

Ports:
- clk  in  1  sole clock, rising edge
- n_rst  in  1  reset, synchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command; high only in IDLE
- cmd_x0, cmd_x1  in  X_W  start and end x (unsigned)
- cmd_y0, cmd_y1  in  Y_W  start and end y (unsigned)
- cmd_skip_last  in  1  suppress the end-point pixel
- abort  in  1  cancel the current line
- pix_valid  out  1  pixel offered
- pix_ready  in  1  consumer accepts the pixel
- pix_x  out  X_W  pixel x
- pix_y  out  Y_W  pixel y
- pix_last  out  1  marks the final emitted pixel of the line
- busy  out  1  state is not IDLE
- line_done  out  1  one-cycle pulse when a line completes normally

## Operation
- States: IDLE, SETUP, STEP.
- IDLE:
  - cmd_ready=1.
  - When cmd_valid is high, latch x0, y0, x1, y1 and skip_last, then go to SETUP.
- SETUP (one cycle):
  - right = x1>=x0; dx = |x1-x0|.
  - down = y1>=y0; dy = -|y1-y0|.
  - err = dx+dy; (cx,cy) = (x0,y0).
  - Go to STEP.
- Arithmetic width: W = max(X_W,Y_W)+2, signed. e2 = 2*err at W+1 bits. Intermediates must never wrap.
- STEP:
  - Present (cx,cy) with pix_valid=1.
  - On handshake (pix_valid && pix_ready):
    - If (cx,cy)==(x1,y1), go to IDLE.
    - Otherwise: if e2>dy then err+=dy and cx±=1; if e2<dx then err+=dx and cy±=1. Both updates use the pre-update e2.
  - Without a handshake, pix_x, pix_y and pix_last stay stable.
- pix_last:
  - Asserted on the end-point pixel.
  - With skip_last, asserted on the pixel before the end point, and the end point itself is never presented; the block returns to IDLE after that handshake.
- Degenerate line (x0==x1, y0==y1):
  - Without skip_last: one pixel, pix_last=1.
  - With skip_last: zero pixels; STEP lasts one cycle with pix_valid=0, then line_done pulses.
- abort:
  - Overrides everything in any state.
  - Next cycle: IDLE, pix_valid=0, no line_done pulse.
  - In IDLE, abort blocks command acceptance for that cycle.

## Timing
- Reset values: cmd_ready=1; pix_valid=0; pix_x=0; pix_y=0; pix_last=0; busy=0; line_done=0. All internal registers are cleared.
- Command handshake at cycle T:
  - SETUP at T+1.
  - First pix_valid at T+2.
- Throughput: one pixel per cycle while pix_ready is held high.
- Completion: final pixel handshake at cycle N means IDLE at N+1, with line_done=1 and cmd_ready=1 in that same cycle. The next command can be accepted at N+1.
- An N-pixel line under continuous ready occupies busy for N+1 cycles.
- pix_valid never drops without a handshake, except on abort or reset.
- Reset mid-line behaves like abort, and all outputs return to their reset values.

## Configuration
- LINE_CLIP_EN defined:
  - In STEP, a pixel with cx>X_MAX or cy>Y_MAX is not presented (pix_valid=0), and the stepper advances that cycle without waiting for pix_ready.
  - pix_last is marked only on the last pixel that is visible and actually emitted.
  - line_done still pulses even if the whole line is clipped.
  - Clipping evaluation must add no latency.
- LINE_CLIP_EN undefined:
  - X_MAX and Y_MAX are ignored.
  - Every pixel is presented.

## Structure
- Shared package gpu_line_pkg holds:
  - the state enum (IDLE, SETUP, STEP)
  - a parametrised coordinate struct type
  - the width helper function for W
- One sub-module, bresen_step: purely combinational. It takes err, dx, dy, cx, cy, right and down, and returns next err, cx and cy, plus an at_end flag.
- The top level holds the FSM, handshakes and clipping.

## Test plan
- (0,0)->(3,0), ready always high -> pixels (0,0), (1,0), (2,0), (3,0) on cycles T+2..T+5; pix_last on (3,0); line_done at T+6.
- (5,1)->(2,7), steep with negative x -> 7 pixels starting (5,1) and ending (2,7); every step changes cy by 1 and cx by 0 or -1; the sequence matches the golden model.
- (0,0)->(4,2) with pix_ready toggling 1,0,0,1,... -> pixel values held stable while stalled; same 5 pixels as the unstalled run; no pixel dropped or duplicated.
- (9,9)->(9,9) with skip_last=1 -> no pix_valid; line_done pulses at T+3; (9,9)->(9,9) with skip_last=0 -> one pixel with pix_last.
- (0,0)->(10,10), abort asserted after the third handshake -> IDLE next cycle; pix_valid=0; no line_done; a new command is accepted one cycle later.
- LINE_CLIP_EN with X_MAX=3: (0,0)->(6,0) -> pixels x=0..3 emitted with pix_last on x=3; line_done at T+9.
